smoldvi_timing_gen: RTL

Raster timing generator and sequencer for the SmolDVI TMDS encoders. It produces the per-cycle `den` and control-symbol inputs (`c[1:0]` carrying hsync/vsync) for the TMDS lane encoders, and issues a one-cycle pixel request on the first cycle of each pixel pair, so upstream pixel sources deliver one pixel per two clocks. It sits between the framebuffer/scanout logic and the three encoder instances.

---
 rtl/smoldvi_timing_gen_if.sv | 12 +
 rtl/smoldvi_timing_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/smoldvi_timing_gen_if.sv
// Raster timing bundle between the SmolDVI timing generator and its consumers.
// The generator side drives timing outputs and receives the run enable.
interface smoldvi_timing_gen_if;
  logic       en;
  logic       den;
  logic [1:0] c;
  logic       pix_rdy;
  logic       sof;

  modport master (input en, output den, c, pix_rdy, sof);
  modport slave  (output en, input den, c, pix_rdy, sof);
endinterface

// File: rtl/smoldvi_timing_gen.sv
// Raster timing generator for the SmolDVI TMDS lanes: den, sync control symbols,
// a pixel request on the first cycle of each pixel pair, and a start-of-frame pulse.
module smoldvi_timing_gen #(
  parameter int   H_FRONT_PORCH = 16,
  parameter int   H_SYNC_WIDTH  = 96,
  parameter int   H_BACK_PORCH  = 48,
  parameter int   H_ACTIVE      = 640,
  parameter int   V_FRONT_PORCH = 10,
  parameter int   V_SYNC_WIDTH  = 2,
  parameter int   V_BACK_PORCH  = 33,
  parameter int   V_ACTIVE      = 480,
  parameter logic H_SYNC_POL    = 1'b0,
  parameter logic V_SYNC_POL    = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  smoldvi_timing_gen_if.master bus
);

  localparam logic [1:0] ST_FRONT  = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_BACK   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam logic [1:0] C_IDLE = {~V_SYNC_POL, ~H_SYNC_POL};

  function automatic logic [11:0] h_load(input logic [1:0] st);
    case (st)
      ST_FRONT: h_load = 12'(H_FRONT_PORCH - 1);
      ST_SYNC:  h_load = 12'(H_SYNC_WIDTH - 1);
      ST_BACK:  h_load = 12'(H_BACK_PORCH - 1);
      default:  h_load = 12'(H_ACTIVE - 1);
    endcase
  endfunction

  function automatic logic [11:0] v_load(input logic [1:0] st);
    case (st)
      ST_FRONT: v_load = 12'(V_FRONT_PORCH - 1);
      ST_SYNC:  v_load = 12'(V_SYNC_WIDTH - 1);
      ST_BACK:  v_load = 12'(V_BACK_PORCH - 1);
      default:  v_load = 12'(V_ACTIVE - 1);
    endcase
  endfunction

  logic        running;
  logic [11:0] x, y;
  logic [1:0]  h_state, v_state;
  logic [11:0] h_cnt, v_cnt;

  logic [11:0] nx, ny;
  logic [1:0]  nh_state, nv_state;
  logic [11:0] nh_cnt, nv_cnt;
  logic        n_den;

  logic        den_q, pix_rdy_q, sof_q;
  logic [1:0]  c_q;

  // Position of the cycle that follows the next edge: (0,0) when starting,
  // otherwise one step along the raster.
  always_comb begin
    nx       = '0;
    ny       = '0;
    nh_state = ST_FRONT;
    nh_cnt   = h_load(ST_FRONT);
    nv_state = ST_FRONT;
    nv_cnt   = v_load(ST_FRONT);
    if (running) begin
      nx       = x + 12'd1;
      ny       = y;
      nh_state = h_state;
      nh_cnt   = h_cnt - 12'd1;
      nv_state = v_state;
      nv_cnt   = v_cnt;
      if (h_cnt == '0) begin
        nh_state = 2'(h_state + 2'd1);
        nh_cnt   = h_load(nh_state);
        if (h_state == ST_ACTIVE) begin
          nx     = '0;
          ny     = y + 12'd1;
          nv_cnt = v_cnt - 12'd1;
          if (v_cnt == '0) begin
            nv_state = 2'(v_state + 2'd1);
            nv_cnt   = v_load(nv_state);
            if (v_state == ST_ACTIVE) ny = '0;
          end
        end
      end
    end
  end

  assign n_den = (nh_state == ST_ACTIVE) && (nv_state == ST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      x         <= '0;
      y         <= '0;
      h_state   <= ST_FRONT;
      h_cnt     <= '0;
      v_state   <= ST_FRONT;
      v_cnt     <= '0;
      den_q     <= 1'b0;
      pix_rdy_q <= 1'b0;
      sof_q     <= 1'b0;
      c_q       <= C_IDLE;
    end else if (!bus.en) begin
      running   <= 1'b0;
      x         <= '0;
      y         <= '0;
      h_state   <= ST_FRONT;
      h_cnt     <= '0;
      v_state   <= ST_FRONT;
      v_cnt     <= '0;
      den_q     <= 1'b0;
      pix_rdy_q <= 1'b0;
      sof_q     <= 1'b0;
      c_q       <= C_IDLE;
    end else begin
      running   <= 1'b1;
      x         <= nx;
      y         <= ny;
      h_state   <= nh_state;
      h_cnt     <= nh_cnt;
      v_state   <= nv_state;
      v_cnt     <= nv_cnt;
      den_q     <= n_den;
      // H_ACTIVE is even, so the active down-counter is odd on even pixel offsets.
      pix_rdy_q <= n_den && nh_cnt[0];
      sof_q     <= (nx == '0) && (ny == '0);
      c_q[0]    <= (nh_state == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      c_q[1]    <= (nv_state == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  assign bus.den     = den_q;
  assign bus.c       = c_q;
  assign bus.pix_rdy = pix_rdy_q;
  assign bus.sof     = sof_q;

endmodule
